// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
// Bundles the requester handshakes and the shared-ALU connection of
// alu_share_arbiter.
//   slave  modport : the arbiter side.
//   master modport : the requesters plus the ALU (testbench / integration).
// Signals:
//   req_valid/req_ready   [1:0]   request handshake, bit i = port i
//   req_op                [2*OL]  port i opcode at [i*OL +: OL]
//   req_a / req_b         [2*DW]  port i operands at [i*DW +: DW]
//   resp_valid/resp_ready [1:0]   response handshake, bit i = port i
//   resp_result           [DW]    result shared by both ports
//   alu_srca/alu_srcb     [DW]    to the ALU operands
//   alu_operation         [OL]    to the ALU operation code
//   alu_result            [DW]    from the ALU
//   busy                          arbiter is working on an operation
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [2*OPCODE_LENGTH-1:0] req_op;
  logic [2*DATA_WIDTH-1:0]    req_a;
  logic [2*DATA_WIDTH-1:0]    req_b;
  logic [1:0]                 resp_valid;
  logic [1:0]                 resp_ready;
  logic [DATA_WIDTH-1:0]      resp_result;
  logic [DATA_WIDTH-1:0]      alu_srca;
  logic [DATA_WIDTH-1:0]      alu_srcb;
  logic [OPCODE_LENGTH-1:0]   alu_operation;
  logic [DATA_WIDTH-1:0]      alu_result;
  logic                       busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, alu_result,
    output req_ready, resp_valid, resp_result,
           alu_srca, alu_srcb, alu_operation, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, alu_result,
    input  req_ready, resp_valid, resp_result,
           alu_srca, alu_srcb, alu_operation, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between two requesters (port 0: execute stage,
// port 1: address/aux unit). An operation is accepted in IDLE, the latched
// operands drive the ALU in EXEC where the result is registered, and the
// result is presented to the owning port in RESP until that port takes it.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    alu_share_arbiter_if.slave (handshakes + ALU connection)
// Configuration:
//   ALU_ARB_RR_EN defined   : round-robin on contention (last_grant register)
//   ALU_ARB_RR_EN undefined : fixed priority, port 0 wins contention
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  alu_share_arbiter_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int OL = OPCODE_LENGTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q,      state_d;
  logic [OL-1:0]   op_q,         op_d;
  logic [DW-1:0]   a_q,          a_d;
  logic [DW-1:0]   b_q,          b_d;
  logic            owner_q,      owner_d;
  logic [DW-1:0]   result_q,     result_d;
  logic [1:0]      resp_valid_q, resp_valid_d;
  logic            busy_q,       busy_d;
`ifdef ALU_ARB_RR_EN
  logic            last_grant_q, last_grant_d;
`endif

  logic            grant_vld_s;
  logic            grant_idx_s;

  // Pick the port that wins this cycle from the raw request lines.
  always_comb begin
    grant_vld_s = |bus.req_valid;
`ifdef ALU_ARB_RR_EN
    // On contention the port that did not win last time goes first.
    if (bus.req_valid == 2'b11) begin
      grant_idx_s = ~last_grant_q;
    end else begin
      grant_idx_s = ~bus.req_valid[0];
    end
`else
    grant_idx_s = ~bus.req_valid[0];
`endif
  end

  // Acceptance is combinational so a requester sees ready in its valid cycle.
  always_comb begin
    if ((state_q == ST_IDLE) && grant_vld_s) begin
      bus.req_ready = grant_idx_s ? 2'b10 : 2'b01;
    end else begin
      bus.req_ready = 2'b00;
    end
  end

  // Next-state and next-register values for the whole operation sequence.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    owner_d      = owner_q;
    result_d     = result_q;
    resp_valid_d = resp_valid_q;
`ifdef ALU_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_vld_s) begin
          op_d    = grant_idx_s ? bus.req_op[2*OL-1:OL] : bus.req_op[OL-1:0];
          a_d     = grant_idx_s ? bus.req_a[2*DW-1:DW]  : bus.req_a[DW-1:0];
          b_d     = grant_idx_s ? bus.req_b[2*DW-1:DW]  : bus.req_b[DW-1:0];
          owner_d = grant_idx_s;
          state_d = ST_EXEC;
`ifdef ALU_ARB_RR_EN
          last_grant_d = grant_idx_s;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // The ALU already sees the latched operands; take its answer now.
        result_d     = bus.alu_result;
        resp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        // Only the owner's ready releases the response.
        if (bus.resp_ready[owner_q]) begin
          resp_valid_d = 2'b00;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        resp_valid_d = 2'b00;
        state_d      = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= {OL{1'b0}};
      a_q          <= {DW{1'b0}};
      b_q          <= {DW{1'b0}};
      owner_q      <= 1'b0;
      result_q     <= {DW{1'b0}};
      resp_valid_q <= 2'b00;
      busy_q       <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      owner_q      <= owner_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
`ifdef ALU_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // ALU operands come straight from the latched registers, so they hold the
  // last accepted operation outside EXEC.
  assign bus.alu_operation = op_q;
  assign bus.alu_srca      = a_q;
  assign bus.alu_srcb      = b_q;
  assign bus.resp_result   = result_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Self-checking bench for alu_share_arbiter. Provides a behavioural ALU and
// compares every cycle against a transaction-level reference model (pending
// operation, its age, its owner and its expected result), followed by
// directed scenarios and a randomized run. Honours ALU_ARB_RR_EN.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int OL = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) bus ();

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural ALU: AND, OR, ADD, SUB, SLT, XOR; anything else returns 0.
  function automatic logic [DW-1:0] alu_ref(input logic [OL-1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a - b;
      4'b0100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0101: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  assign bus.alu_result = alu_ref(bus.alu_operation, bus.alu_srca, bus.alu_srcb);

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one pending operation with an age (1 = executing,
  // 2 = waiting to be consumed).
  bit            m_pend;
  int            m_age;
  bit            m_owner;
  bit            m_last_grant;
  logic [OL-1:0] m_op;
  logic [DW-1:0] m_a, m_b, m_exp, m_last_res;
  logic [1:0]    grants_q[$];

  task automatic model_reset();
    m_pend = 1'b0; m_age = 0; m_owner = 1'b0; m_last_grant = 1'b1;
    m_op = 4'd0; m_a = 32'd0; m_b = 32'd0; m_exp = 32'd0; m_last_res = 32'd0;
  endtask

  function automatic bit model_grant(input logic [1:0] v);
`ifdef ALU_ARB_RR_EN
    if (v == 2'b11) return ~m_last_grant;
`endif
    return v[0] ? 1'b0 : 1'b1;
  endfunction

  // One clock cycle: apply inputs at the falling edge, check, advance model.
  task automatic cycle(input logic [1:0] v,
                       input logic [OL-1:0] op0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                       input logic [OL-1:0] op1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                       input logic [1:0] rr);
    logic [1:0] e_rdy;
    logic [1:0] e_rv;
    bit         g;
    bus.req_valid  = v;
    bus.req_op     = {op1, op0};
    bus.req_a      = {a1, a0};
    bus.req_b      = {b1, b0};
    bus.resp_ready = rr;
    #1;
    g     = model_grant(v);
    e_rdy = (!m_pend && (v != 2'b00)) ? (g ? 2'b10 : 2'b01) : 2'b00;
    e_rv  = (m_pend && (m_age == 2)) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    check_val("req_ready",   bus.req_ready,     e_rdy);
    check_val("resp_valid",  bus.resp_valid,    e_rv);
    check_val("resp_result", bus.resp_result,   m_last_res);
    check_val("busy",        bus.busy,          m_pend);
    check_val("alu_op",      bus.alu_operation, m_op);
    check_val("alu_srca",    bus.alu_srca,      m_a);
    check_val("alu_srcb",    bus.alu_srcb,      m_b);
    if (bus.req_ready != 2'b00) grants_q.push_back(bus.req_ready);
    if (!m_pend) begin
      if (v != 2'b00) begin
        m_pend = 1'b1; m_age = 1; m_owner = g; m_last_grant = g;
        m_op = g ? op1 : op0;
        m_a  = g ? a1 : a0;
        m_b  = g ? b1 : b0;
        m_exp = alu_ref(m_op, m_a, m_b);
      end
    end else if (m_age == 1) begin
      m_last_res = m_exp;
      m_age = 2;
    end else if (rr[m_owner]) begin
      m_pend = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic [1:0] rr);
    cycle(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, rr);
  endtask

  logic [1:0] v_r, rr_r;
  logic [OL-1:0] op0_r, op1_r;
  logic [DW-1:0] a0_r, b0_r, a1_r, b1_r;

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 2'b00; bus.req_op = 8'd0; bus.req_a = 64'd0;
    bus.req_b = 64'd0; bus.resp_ready = 2'b00;
    model_reset();
    #1;
    check_val("rst_busy",       bus.busy,       1'b0);
    check_val("rst_resp_valid", bus.resp_valid, 2'b00);
    check_val("rst_result",     bus.resp_result, 32'd0);
    check_val("rst_srca",       bus.alu_srca,   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2'b00);

    // Contention straight after reset: port 0 wins first.
    grants_q.delete();
    for (int i = 0; i < 12; i++)
      cycle(2'b11, 4'b0010, i, 32'd1, 4'b0011, i, 32'd1, 2'b11);
    check_val("cont_count", grants_q.size(), 4);
    for (int i = 0; i < grants_q.size(); i++) begin
`ifdef ALU_ARB_RR_EN
      check_val("cont_rr", grants_q[i], (i % 2 == 0) ? 2'b01 : 2'b10);
`else
      check_val("cont_fixed", grants_q[i], 2'b01);
`endif
    end

    // Port 0 ADD 5 + 7.
    cycle(2'b01, 4'b0010, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 2'b00);
    check_val("add_busy_exec", bus.busy, 1'b1);
    idle(2'b00);
    check_val("add_rv", bus.resp_valid, 2'b01);
    check_val("add_res", bus.resp_result, 32'd12);
    idle(2'b01);
    check_val("add_busy_done", bus.busy, 1'b0);

    // Port 1 SUB 0 - 1; port 0's ready must not release it.
    cycle(2'b10, 4'd0, 32'd0, 32'd0, 4'b0011, 32'd0, 32'd1, 2'b00);
    idle(2'b00);
    check_val("sub_rv", bus.resp_valid, 2'b10);
    check_val("sub_res", bus.resp_result, 32'hFFFF_FFFF);
    idle(2'b01);
    check_val("sub_hold_rv", bus.resp_valid, 2'b10);
    idle(2'b10);

    // Port 0 SLT 3 < 9 stalled by its consumer while port 1 keeps asking.
    cycle(2'b11, 4'b0100, 32'd3, 32'd9, 4'b0010, 32'd4, 32'd4, 2'b00);
    cycle(2'b11, 4'b0100, 32'd3, 32'd9, 4'b0010, 32'd4, 32'd4, 2'b00);
    for (int i = 0; i < 5; i++) begin
      check_val("slt_res", bus.resp_result, 32'd1);
      check_val("slt_rv", bus.resp_valid, 2'b01);
      cycle(2'b11, 4'b0100, 32'd3, 32'd9, 4'b0010, 32'd4, 32'd4, 2'b10);
    end
    cycle(2'b11, 4'b0100, 32'd3, 32'd9, 4'b0010, 32'd4, 32'd4, 2'b01);
    idle(2'b11);
    idle(2'b11);
    idle(2'b11);

    // Unknown opcode returns 0.
    cycle(2'b01, 4'b1111, 32'd1, 32'd1, 4'd0, 32'd0, 32'd0, 2'b00);
    idle(2'b00);
    check_val("unk_res", bus.resp_result, 32'd0);
    idle(2'b01);

    // Reset during EXEC aborts the operation.
    cycle(2'b01, 4'b0010, 32'd9, 32'd9, 4'd0, 32'd0, 32'd0, 2'b00);
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    check_val("rst_exec_rv",   bus.resp_valid, 2'b00);
    check_val("rst_exec_busy", bus.busy,       1'b0);
    check_val("rst_exec_rdy",  bus.req_ready,  2'b00);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(2'b01, 4'b0010, 32'd1, 32'd1, 4'd0, 32'd0, 32'd0, 2'b00);
    idle(2'b00);
    check_val("post_rst_res", bus.resp_result, 32'd2);
    check_val("post_rst_rv",  bus.resp_valid,  2'b01);
    idle(2'b01);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      v_r   = 2'($urandom_range(0, 3));
      rr_r  = 2'($urandom_range(0, 3));
      op0_r = 4'($urandom_range(0, 7));
      op1_r = 4'($urandom_range(0, 7));
      a0_r  = $urandom();
      b0_r  = ($urandom_range(0, 3) == 0) ? a0_r : $urandom();
      a1_r  = $urandom();
      b1_r  = $urandom();
      cycle(v_r, op0_r, a0_r, b0_r, op1_r, a1_r, b1_r, rr_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
